// File: rtl/instr_fetch_issue.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_issue
// Brief    : PC owner; fetches 8-bit instructions over req/ack and issues them
//            to the control/ALU datapath. Optional macro: FETCH_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_issue #(
   parameter int              PC_W        = 8,
   parameter logic [PC_W-1:0] RESET_PC    = '0,
   parameter int              ACK_TIMEOUT = 15
) (
   input  logic            ck,
   input  logic            rst,
   input  logic            start,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [7:0]      imem_data,
   output logic [2:0]      op,
   output logic [4:0]      field,
   output logic            last_bit,
   output logic            issue_valid,
   input  logic            exec_done,
   input  logic            pc_src,
   input  logic [PC_W-1:0] pc_target,
   output logic [PC_W-1:0] pc,
   output logic            halted,
   output logic            fetch_err
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT_EXEC = 3'd3,
      S_HALT      = 3'd4
   } state_t;

   localparam logic [7:0]      c_halt_instr = 8'hFF;
   localparam logic [PC_W-1:0] c_pc_one     = PC_W'(1);

   state_t          r_state, w_state_nxt;
   logic [PC_W-1:0] r_pc, w_pc_nxt, w_pc_exec;
   logic [7:0]      r_instr, w_instr_nxt;
   logic            w_timeout;

`ifdef FETCH_TIMEOUT_EN
   localparam logic [7:0] c_timeout_last = 8'(ACK_TIMEOUT - 1);

   logic [7:0] r_cnt;
   logic       r_fetch_err;

   // Counts ack-less FETCH cycles; leaving FETCH clears it so every entry starts at 0.
   always_ff @(posedge ck or posedge rst) begin
      if (rst)
         r_cnt <= 8'd0;
      else if (r_state != S_FETCH)
         r_cnt <= 8'd0;
      else if (!imem_ack)
         r_cnt <= r_cnt + 8'd1;
   end

   assign w_timeout = (r_state == S_FETCH) && !imem_ack && (r_cnt == c_timeout_last);

   always_ff @(posedge ck or posedge rst) begin
      if (rst)
         r_fetch_err <= 1'b0;
      else if (w_timeout)
         r_fetch_err <= 1'b1;
   end

   assign fetch_err = r_fetch_err;
`else
   logic [7:0] w_unused_timeout;

   assign w_unused_timeout = 8'(ACK_TIMEOUT);
   assign w_timeout        = 1'b0;
   assign fetch_err        = 1'b0;
`endif

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= 8'h00;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_instr <= w_instr_nxt;
      end
   end

   assign w_pc_exec = pc_src ? (r_pc + c_pc_one) : pc_target;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      imem_req    = 1'b0;
      issue_valid = 1'b0;
      halted      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start)
               w_state_nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            // A late ack beats a timeout expiring in the same cycle.
            if (imem_ack) begin
               w_instr_nxt = imem_data;
               w_state_nxt = S_ISSUE;
            end else if (w_timeout) begin
               w_state_nxt = S_HALT;
            end
         end
         S_ISSUE: begin
            if (r_instr == c_halt_instr) begin
               w_state_nxt = S_HALT;
            end else begin
               issue_valid = 1'b1;
               if (exec_done) begin
                  w_pc_nxt    = w_pc_exec;
                  w_state_nxt = S_FETCH;
               end else begin
                  w_state_nxt = S_WAIT_EXEC;
               end
            end
         end
         S_WAIT_EXEC: begin
            if (exec_done) begin
               w_pc_nxt    = w_pc_exec;
               w_state_nxt = S_FETCH;
            end
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign imem_addr = r_pc;
   assign pc        = r_pc;
   assign op        = r_instr[7:5];
   assign field     = r_instr[4:0];
   assign last_bit  = r_instr[0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_issue
// Brief    : Randomized self-checking bench for instr_fetch_issue against a
//            program-level model (memory array + expected PC).
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_issue;

   localparam int              PC_W        = 8;
   localparam logic [PC_W-1:0] RESET_PC    = 8'h00;
   localparam int              ACK_TIMEOUT = 15;

   logic            ck = 1'b0;
   logic            rst, start, imem_ack, exec_done, pc_src;
   logic [7:0]      imem_data;
   logic [PC_W-1:0] pc_target, imem_addr, pc;
   logic            imem_req, last_bit, issue_valid, halted, fetch_err;
   logic [2:0]      op;
   logic [4:0]      field;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   logic [7:0]      mem [256];
   logic [PC_W-1:0] mpc;

   initial forever #5 ck = ~ck;
   always @(posedge ck) cyc <= cyc + 1;

   instr_fetch_issue #(
      .PC_W(PC_W), .RESET_PC(RESET_PC), .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .ck(ck), .rst(rst), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
      .op(op), .field(field), .last_bit(last_bit), .issue_valid(issue_valid),
      .exec_done(exec_done), .pc_src(pc_src), .pc_target(pc_target),
      .pc(pc), .halted(halted), .fetch_err(fetch_err)
   );

   task automatic fill_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i] = 8'($urandom);
         if (mem[i] == 8'hFF) mem[i] = 8'hFE;
      end
   endtask

   task automatic do_reset();
      @(negedge ck);
      rst = 1'b1; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
      @(negedge ck);
      rst = 1'b0;
      mpc = RESET_PC;
   endtask

   task automatic begin_run();
      start = 1'b1;
      @(negedge ck);
      start = 1'b0;
   endtask

   // One instruction: ack after ackdly extra FETCH cycles, exec_done after exdly WAIT cycles.
   task automatic step_instr(input int ackdly, input int exdly, input bit src, input logic [PC_W-1:0] tgt);
      logic [7:0] ins;
      nvec++;
      if (imem_req !== 1'b1 || imem_addr !== mpc) begin
         nerr++; $display("FAIL fetch_start: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, mpc);
      end
      for (int i = 0; i < ackdly; i++) begin
         exec_done = 1'($urandom_range(0, 1)); pc_src = 1'b0; pc_target = ~mpc;
         @(negedge ck);
         nvec++;
         if (imem_req !== 1'b1 || imem_addr !== mpc || pc !== mpc) begin
            nerr++; $display("FAIL fetch_hold: req=%b addr=%h pc=%h, expected req=1 addr=pc=%h", imem_req, imem_addr, pc, mpc);
         end
      end
      exec_done = 1'b0;
      ins = mem[mpc]; imem_ack = 1'b1; imem_data = ins;
      @(negedge ck);
      imem_ack = 1'b0; imem_data = 8'($urandom);
      if (ins == 8'hFF) begin
         nvec++;
         if (issue_valid !== 1'b0 || imem_req !== 1'b0) begin
            nerr++; $display("FAIL halt_issue: issue_valid=%b req=%b, expected 0 0", issue_valid, imem_req);
         end
         @(negedge ck);
         nvec++;
         if (halted !== 1'b1 || pc !== mpc || imem_req !== 1'b0) begin
            nerr++; $display("FAIL halt_enter: halted=%b pc=%h req=%b, expected 1 %h 0", halted, pc, imem_req, mpc);
         end
      end else begin
         nvec++;
         if ({issue_valid, op, field, last_bit, imem_req} !== {1'b1, ins[7:5], ins[4:0], ins[0], 1'b0}) begin
            nerr++; $display("FAIL issue: v=%b op=%h field=%h lb=%b req=%b, expected 1 %h %h %b 0 (instr %h)",
                             issue_valid, op, field, last_bit, imem_req, ins[7:5], ins[4:0], ins[0], ins);
         end
         pc_src = src; pc_target = tgt;
         for (int i = 0; i < exdly; i++) begin
            @(negedge ck);
            nvec++;
            if (issue_valid !== 1'b0 || imem_req !== 1'b0 || {op, field} !== ins) begin
               nerr++; $display("FAIL wait_exec: v=%b req=%b instr=%h, expected 0 0 %h", issue_valid, imem_req, {op, field}, ins);
            end
         end
         exec_done = 1'b1;
         @(negedge ck);
         exec_done = 1'b0;
         mpc = src ? mpc + 8'd1 : tgt;
      end
   endtask

   task automatic test_reset();
      do_reset();
      nvec++;
      if ({imem_req, issue_valid, halted, fetch_err, op, field, last_bit} !== 15'd0 || pc !== RESET_PC) begin
         nerr++; $display("FAIL reset_state: req=%b v=%b h=%b err=%b op=%h f=%h lb=%b pc=%h, expected all 0 pc=%h",
                          imem_req, issue_valid, halted, fetch_err, op, field, last_bit, pc, RESET_PC);
      end
      imem_ack = 1'b1; exec_done = 1'b1;
      @(negedge ck);
      imem_ack = 1'b0; exec_done = 1'b0;
      nvec++;
      if (imem_req !== 1'b0 || issue_valid !== 1'b0 || pc !== RESET_PC) begin
         nerr++; $display("FAIL idle_quiet: req=%b v=%b pc=%h, expected 0 0 %h", imem_req, issue_valid, pc, RESET_PC);
      end
   endtask

   task automatic test_basic_and_branch();
      do_reset(); fill_mem();
      mem[0] = 8'h41; mem[1] = 8'h61;
      begin_run();
      step_instr(1, 1, 1'b1, 8'h77);
      step_instr(0, 2, 1'b0, 8'h20);
      step_instr(2, 0, 1'b1, 8'h00);
   endtask

   task automatic test_zero_wait();
      int c0;
      do_reset(); fill_mem();
      begin_run();
      c0 = cyc;
      for (int i = 0; i < 4; i++) step_instr(0, 0, 1'b1, 8'($urandom));
      nvec++;
      if (cyc - c0 != 8 || pc !== 8'h04) begin
         nerr++; $display("FAIL zero_wait_rate: cycles=%0d pc=%h, expected 8 04", cyc - c0, pc);
      end
   endtask

   task automatic test_wrap();
      do_reset(); fill_mem();
      mem[8'hFF] = 8'h40;
      begin_run();
      step_instr(0, 0, 1'b0, 8'hFF);
      step_instr(1, 1, 1'b1, 8'h33);
      step_instr(0, 0, 1'b1, 8'h00);
   endtask

   task automatic test_random();
      do_reset(); fill_mem();
      begin_run();
      for (int i = 0; i < 40; i++)
         step_instr($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom));
   endtask

   task automatic test_halt();
      do_reset(); fill_mem();
      mem[0] = 8'hFE; mem[1] = 8'hFF;
      begin_run();
      step_instr(1, 0, 1'b1, 8'h10);
      step_instr(2, 0, 1'b1, 8'h10);
      for (int i = 0; i < 5; i++) begin
         start = 1'b1; exec_done = 1'b1; pc_src = 1'($urandom_range(0, 1)); pc_target = 8'($urandom);
         @(negedge ck);
         nvec++;
         if (halted !== 1'b1 || pc !== 8'h01 || imem_req !== 1'b0 || issue_valid !== 1'b0) begin
            nerr++; $display("FAIL halt_frozen: h=%b pc=%h req=%b v=%b, expected 1 01 0 0", halted, pc, imem_req, issue_valid);
         end
      end
      start = 1'b0; exec_done = 1'b0;
      do_reset();
      nvec++;
      if (halted !== 1'b0 || pc !== RESET_PC) begin
         nerr++; $display("FAIL halt_reset: h=%b pc=%h, expected 0 %h", halted, pc, RESET_PC);
      end
   endtask

   task automatic test_reset_mid_fetch();
      do_reset();
      begin_run();
      @(negedge ck);
      rst = 1'b1;
      #1;
      nvec++;
      if (imem_req !== 1'b0 || pc !== RESET_PC) begin
         nerr++; $display("FAIL reset_mid_fetch: req=%b pc=%h, expected 0 %h", imem_req, pc, RESET_PC);
      end
      @(negedge ck);
      rst = 1'b0; imem_ack = 1'b1; imem_data = 8'h41;
      @(negedge ck);
      imem_ack = 1'b0;
      nvec++;
      if (issue_valid !== 1'b0 || imem_req !== 1'b0 || {op, field} !== 8'h00) begin
         nerr++; $display("FAIL stale_ack: v=%b req=%b instr=%h, expected 0 0 00", issue_valid, imem_req, {op, field});
      end
   endtask

   task automatic test_timeout();
      int n;
      do_reset(); fill_mem();
      begin_run();
`ifdef FETCH_TIMEOUT_EN
      step_instr(ACK_TIMEOUT - 1, 0, 1'b1, 8'h00);
      nvec++;
      if (fetch_err !== 1'b0 || halted !== 1'b0) begin
         nerr++; $display("FAIL ack_wins: err=%b h=%b, expected 0 0", fetch_err, halted);
      end
      do_reset();
      begin_run();
      n = 0;
      while (imem_req === 1'b1 && n < 100) begin
         n++;
         @(negedge ck);
      end
      nvec++;
      if (n != ACK_TIMEOUT || fetch_err !== 1'b1 || halted !== 1'b1) begin
         nerr++; $display("FAIL timeout: req_cycles=%0d err=%b h=%b, expected %0d 1 1", n, fetch_err, halted, ACK_TIMEOUT);
      end
`else
      n = 0;
      while (imem_req === 1'b1 && n < 40) begin
         n++;
         @(negedge ck);
      end
      nvec++;
      if (n != 40 || fetch_err !== 1'b0 || halted !== 1'b0) begin
         nerr++; $display("FAIL no_timeout: req_cycles=%0d err=%b h=%b, expected 40 0 0", n, fetch_err, halted);
      end
`endif
      do_reset();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; imem_ack = 1'b0; imem_data = 8'h00;
      exec_done = 1'b0; pc_src = 1'b0; pc_target = '0; mpc = RESET_PC;
      test_reset();
      test_basic_and_branch();
      test_zero_wait();
      test_wrap();
      test_random();
      test_halt();
      test_reset_mid_fetch();
      test_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Instruction fetch/issue sequencer that drives the opcode side of the single-cycle control decoder.
- Owns the PC and fetches 8-bit instructions from instruction memory over a req/ack handshake.
- Splits each instruction into op[2:0] / field[4:0] / last_bit and issues it to the control/ALU datapath.
- Takes the PC source decision back from the datapath and detects the halt instruction (8'hFF).

Parameters:
- PC_W, 8, width of PC and instruction-memory address.
- RESET_PC, 0, PC value loaded on reset.
- ACK_TIMEOUT, 15, max cycles waiting for imem_ack (used only with the optional feature); range 1..255.

Ports:
- ck  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching; ignored in every other state.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  PC_W  read address; always equals pc.
- imem_ack  in  1  memory has valid data on imem_data this cycle.
- imem_data  in  8  instruction word.
- op  out  3  instr[7:5], to control decoder.
- field  out  5  instr[4:0], register/immediate field.
- last_bit  out  1  instr[0], branch-condition bit to control decoder.
- issue_valid  out  1  one-cycle pulse: op/field/last_bit hold a new instruction.
- exec_done  in  1  datapath finished the issued instruction; pc_src/pc_target valid this cycle.
- pc_src  in  1  1 = next PC is pc+1; 0 = next PC is pc_target.
- pc_target  in  PC_W  jump/branch/return target.
- pc  out  PC_W  current PC.
- halted  out  1  halt instruction reached.
- fetch_err  out  1  fetch timeout flag; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, instruction register=8'h00 (so op=0, field=0, last_bit=0).
  - imem_req=0, issue_valid=0, halted=0, fetch_err=0.
  - Reset mid-fetch drops imem_req in the same cycle; any ack still in flight afterwards is ignored (we are in IDLE).
- States: IDLE, FETCH, ISSUE, WAIT_EXEC, HALT.
- IDLE:
  - outputs quiet.
  - start=1 at edge N: FETCH from edge N, so imem_req=1 in cycle N+1.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack is sampled high.
  - On ack: latch imem_data into the instruction register and go to ISSUE; imem_req falls the next cycle.
  - An ack in the same cycle req first rises is legal (zero-wait memory).
- ISSUE (exactly one cycle):
  - If instr==8'hFF: issue_valid=0, go to HALT.
  - Otherwise: issue_valid=1 and go to WAIT_EXEC.
  - exec_done=1 during ISSUE is accepted (single-cycle execution): apply the PC update and go straight to FETCH.
  - 8'hE0..8'hFE (op=3'b111, "ca") are normal instructions; only the full 8'hFF halts.
- WAIT_EXEC:
  - op/field/last_bit stay stable until the next ack.
  - On exec_done: pc <= pc_src ? pc+1 : pc_target, then go to FETCH.
  - exec_done is ignored in IDLE, FETCH and HALT.
- PC arithmetic: pc+1 is modulo 2^PC_W (pc=8'hFF wraps to 8'h00); pc_target is taken as-is.
- HALT:
  - halted=1, imem_req=0, pc frozen at the halt address; start is ignored.
  - Only rst leaves HALT.
- Fetch-to-issue latency: imem_ack at edge N gives issue_valid high in cycle N+1.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- When defined:
  - an 8-bit counter clears on entry to FETCH and increments every FETCH cycle without ack.
  - When it reaches ACK_TIMEOUT without ack: fetch_err=1 (sticky until rst), imem_req drops, state goes to HALT with halted=1.
  - An ack arriving in the same cycle the count reaches ACK_TIMEOUT wins: normal fetch, no error.
- When undefined: no counter; FETCH waits indefinitely; fetch_err tied 0.

Test Plan:
- Reset then start, memory returns 8'h41 at pc=0 with 2-cycle ack delay -> imem_req high 2 cycles, then issue_valid pulse with op=3'b010, field=5'h01, last_bit=1; exec_done with pc_src=1 -> pc=1, new req at addr 1.
- Branch: issue 8'h61 (op=3'b011, last_bit=1), exec_done with pc_src=0, pc_target=8'h20 -> next imem_addr=8'h20.
- Zero-wait: ack same cycle as req, exec_done during ISSUE -> one instruction per 2 cycles, pc 0,1,2,3 sequential.
- Wrap: pc=8'hFF, instr 8'h40, pc_src=1 -> pc=8'h00.
- Halt: instr 8'hFE issues normally (op=7); next instr 8'hFF -> no issue_valid, halted=1, pc frozen, start and exec_done ignored; rst -> pc=RESET_PC, halted=0.
- FETCH_TIMEOUT_EN defined, ACK_TIMEOUT=15, ack withheld -> fetch_err=1 and halted=1 after 15 FETCH cycles; assert rst mid-fetch in a separate run -> imem_req=0 immediately.
